// File: rtl/router_input_arbiter.sv
// Router input stage: one circular FIFO per port, round-robin grant over the
// non-empty FIFOs, head of the granted FIFO presented to the routing algorithm.
module router_input_arbiter #(
    parameter int PL    = 16,
    parameter int CS    = 2,
    parameter int REN   = 5,
    parameter int REN_B = 3,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:PL-1]     in_packets [0:REN-1],
    output logic [REN-1:0]    availability_out,
    output logic [0:PL-1]     to_algorithm,
    output logic [REN_B-1:0]  shift,
    input  logic [REN-1:0]    shift_signals_in
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [0:PL-1]    mem_q    [REN][DEPTH];
    logic [0:PL-1]    mem_d    [REN][DEPTH];
    logic [AW-1:0]    rd_ptr_q [REN];
    logic [AW-1:0]    rd_ptr_d [REN];
    logic [AW-1:0]    wr_ptr_q [REN];
    logic [AW-1:0]    wr_ptr_d [REN];
    logic [CW-1:0]    count_q  [REN];
    logic [CW-1:0]    count_d  [REN];
    logic [REN_B-1:0] grant_q;
    logic [REN_B-1:0] grant_d;

    logic [REN-1:0]   push_v;
    logic [REN-1:0]   pop_v;
    logic [REN-1:0]   nonempty;
    logic [REN_B-1:0] next_idx;
    logic             next_found;

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        push_v     = '0;
        pop_v      = '0;
        nonempty   = '0;
        next_idx   = grant_q;
        next_found = 1'b0;

        for (int p = 0; p < REN; p++) begin
            nonempty[p] = (count_q[p] != '0);
            // Full is judged on the pre-edge count, so a pop cannot make room
            // for a push in the same cycle.
            push_v[p]   = in_packets[p][0] && (count_q[p] != FULL);
            pop_v[p]    = shift_signals_in[p] && (grant_q == REN_B'(p)) && nonempty[p];

            if (push_v[p]) begin
                mem_d[p][wr_ptr_q[p]] = in_packets[p];
                wr_ptr_d[p]           = wr_ptr_q[p] + AW'(1);
            end
            if (pop_v[p]) begin
                rd_ptr_d[p] = rd_ptr_q[p] + AW'(1);
            end
            case ({push_v[p], pop_v[p]})
                2'b10:   count_d[p] = count_q[p] + CW'(1);
                2'b01:   count_d[p] = count_q[p] - CW'(1);
                default: count_d[p] = count_q[p];
            endcase
        end

        for (int k = 1; k < REN; k++) begin
            int idx;
            idx = int'(grant_q) + k;
            if (idx >= REN) begin
                idx = idx - REN;
            end
            if (!next_found && nonempty[idx]) begin
                next_found = 1'b1;
                next_idx   = REN_B'(idx);
            end
        end

        grant_d = grant_q;
        if ((pop_v[grant_q] || !nonempty[grant_q]) && next_found) begin
            grant_d = next_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < REN; p++) begin
                rd_ptr_q[p] <= '0;
                wr_ptr_q[p] <= '0;
                count_q[p]  <= '0;
            end
            grant_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            grant_q  <= grant_d;
        end
    end

    // Storage needs no reset: contents are only visible through count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int p = 0; p < REN; p++) begin
            availability_out[p] = (count_q[p] != FULL);
        end
        to_algorithm = '0;
        if (count_q[grant_q] != '0) begin
            to_algorithm = mem_q[grant_q][rd_ptr_q[grant_q]];
        end
        shift = grant_q;
    end

endmodule
